fetch_stage: RTL

- IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request, and loads the IF/ID pipeline register.
- Directly consumes the ID-stage branch resolver's `pcSrc`/`flush` pair to redirect fetch and bubble IF/ID.
- Supports variable-latency instruction memory through a req/ack handshake.
- Holds on hazard-unit stall using a one-entry skid buffer.

---
 rtl/fetch_stage_if.sv | 11 +
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and
// the instruction memory. The fetch stage is the master.
interface fetch_stage_if;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;

   modport master (output imemReq, output imemAddr, input imemAck, input imemData);
   modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, issues instruction
// fetches over a req/ack bus, loads the IF/ID register, redirects on ID
// flush and parks one fetched word in a skid buffer while stalled.
// Optional macro FETCH_PERF_EN enables the squash/stall performance counters;
// without it squashCount and stallCount are tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP_INST = 32'h00000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    pcSrc,
   input  logic          flush,
   input  logic [31:0]   branchTarget,
   input  logic [31:0]   jumpTarget,
   input  logic          stall,
   fetch_stage_if.master imem,
   output logic [31:0]   ifidInst,
   output logic [31:0]   ifidPcPlus4,
   output logic          ifidValid,
   output logic [31:0]   pc,
   output logic [31:0]   squashCount,
   output logic [31:0]   stallCount
);

   typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, SQUASH = 2'd2} state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc4;
   } ifid_t;

   localparam ifid_t BUBBLE = '{valid: 1'b0, inst: NOP_INST, pc4: 32'h0};

   state_t      state, stateNext;
   ifid_t       ifid, ifidNext;
   logic [31:0] pcNext;
   logic [31:0] pendTarget, pendNext;
   logic [31:0] skidInst, skidInstNext;
   logic [31:0] skidPc4, skidPc4Next;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pcPlus4;

   // Redirect decode: only pcSrc 01/10 with flush move the PC; the rest bubble only.
   assign redirect = flush && (pcSrc == 2'b01 || pcSrc == 2'b10);
   assign target   = (pcSrc == 2'b01) ? branchTarget : jumpTarget;
   assign pcPlus4  = pc + 32'd4;

   // The address stays on the old PC during SQUASH so it is stable until ack.
   assign imem.imemAddr = pc;
   assign imem.imemReq  = (state != HOLD);

   assign ifidInst    = ifid.inst;
   assign ifidPcPlus4 = ifid.pc4;
   assign ifidValid   = ifid.valid;

   // Next-state and next-register decode, priority flush > stall > ack.
   always_comb begin
      stateNext    = state;
      pcNext       = pc;
      pendNext     = pendTarget;
      skidInstNext = skidInst;
      skidPc4Next  = skidPc4;
      ifidNext     = ifid;
      case (state)
         FETCH: begin
            if (flush) begin
               ifidNext = BUBBLE;
               if (imem.imemAck) begin
                  pcNext = redirect ? target : pc;
               end else begin
                  pendNext  = redirect ? target : pc;
                  stateNext = SQUASH;
               end
            end else if (stall) begin
               if (imem.imemAck) begin
                  skidInstNext = imem.imemData;
                  skidPc4Next  = pcPlus4;
                  pcNext       = pcPlus4;
                  stateNext    = HOLD;
               end
            end else if (imem.imemAck) begin
               ifidNext = '{valid: 1'b1, inst: imem.imemData, pc4: pcPlus4};
               pcNext   = pcPlus4;
            end else begin
               ifidNext = BUBBLE;
            end
         end
         SQUASH: begin
            if (flush || !stall) begin
               ifidNext = BUBBLE;
            end
            // A newer redirect replaces the one still waiting for the old ack.
            if (imem.imemAck) begin
               pcNext    = redirect ? target : pendTarget;
               stateNext = FETCH;
            end else if (redirect) begin
               pendNext = target;
            end
         end
         HOLD: begin
            if (flush) begin
               ifidNext  = BUBBLE;
               pcNext    = redirect ? target : pc;
               stateNext = FETCH;
            end else if (!stall) begin
               ifidNext  = '{valid: 1'b1, inst: skidInst, pc4: skidPc4};
               stateNext = FETCH;
            end
         end
         default: begin
            stateNext = FETCH;
         end
      endcase
   end

   // State, PC and IF/ID register; reset wins over any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         pc    <= RESET_PC;
         ifid  <= BUBBLE;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
         ifid  <= ifidNext;
      end
   end

   // Pending redirect target and skid buffer; their contents only matter in SQUASH/HOLD.
   always_ff @(posedge clk) begin
      pendTarget <= pendNext;
      skidInst   <= skidInstNext;
      skidPc4    <= skidPc4Next;
   end

`ifdef FETCH_PERF_EN
   logic squashEvt;
   logic stallEvt;

   assign squashEvt = (state == HOLD && flush) ||
                      (state != HOLD && imem.imemAck && (flush || state == SQUASH));
   assign stallEvt  = stall && !flush;

   // Wrapping event counters for discarded fetches and stalled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         squashCount <= 32'h0;
         stallCount  <= 32'h0;
      end else begin
         if (squashEvt) squashCount <= squashCount + 32'd1;
         if (stallEvt)  stallCount  <= stallCount + 32'd1;
      end
   end
`else
   assign squashCount = 32'h0;
   assign stallCount  = 32'h0;
`endif

endmodule
